sram_march_tester: RTL and testbench
====================================

// Module: sram_march_tester
// PURPOSE
//  Parametrised March C- tester for an external asynchronous SRAM (16-bit, 256K-word class part).
//  Drives the SRAM pins directly and runs six march elements over a programmable address range.
//  Reports error count, the first failing word and a pass counter to board debug (7-seg, keypad LEDs).
//  Successor to the fixed-pattern SRAM test: adds selectable data background, range limit,
//  configurable access timing, first-fail capture and a loop option.
// PARAMETERS
//  AW         18        SRAM address width
//  DW         16        SRAM data width
//  WAIT_CYC   2         clocks the WE/OE strobe is held low (>=1)
//  ADDR_LAST  2**AW-1   highest address tested; the range is 0..ADDR_LAST
// PORTS
//  clk        in   1    system clock (100 MHz)
//  rst        in   1    synchronous reset, active-high
//  start      in   1    pulse; starts a test when idle
//  bg_sel     in   2    background: 0=0x0000 1=0x5555.. 2=0x3333.. 3=0x0F0F.. (replicated to DW)
//  sram_addr  out  AW   SRAM address
//  sram_data  inout DW  SRAM data bus; tester drives only during writes
//  sram_cs    out  1    chip select, active-low
//  sram_oe    out  1    output enable, active-low
//  sram_we    out  1    write enable, active-low
//  busy       out  1    high while a test runs
//  done       out  1    one-cycle pulse when the last element completes
//  err        out  1    one-cycle pulse on each read mismatch
//  err_cnt    out  16   mismatches since start; saturates at 0xFFFF
//  err_valid  out  1    set when the first mismatch is captured
//  err_addr   out  AW   address of first mismatch
//  err_exp    out  DW   expected word at first mismatch
//  err_got    out  DW   read word at first mismatch
//  pass_cnt   out  8    completed passes since start; wraps
//  elem       out  3    current march element 0..5 (debug)
// BEHAVIOUR
//  Reset: sram_cs/oe/we=1, bus high-Z, sram_addr=0, busy/done/err/err_valid=0.
//  Reset also clears all counters and capture registers and sets elem=0. Reset mid-access aborts at once.
//  On start while idle: bg_sel is latched as B; counters and capture registers clear; busy=1 next cycle.
//  start and bg_sel changes while busy are ignored.
//  Elements use D0=B, D1=~B:
//   E0 up(w D0); E1 up(r D0, w D1); E2 up(r D1, w D0); E3 down(r D0, w D1); E4 down(r D1, w D0); E5 up(r D0).
//  Up runs 0..ADDR_LAST; down runs ADDR_LAST..0. Both operations for an address finish before the address steps.
//  Write access is WAIT_CYC+2 clocks:
//   SETUP: addr, cs=0 and data driven, we=1. Then WAIT_CYC clocks with we=0. Then HOLD: we=1, data still driven.
//  Read access is WAIT_CYC+2 clocks:
//   SETUP: addr and cs=0, bus released. Then WAIT_CYC clocks with oe=0; data is sampled on the last of them.
//   Then TURN: oe=1, bus still high-Z.
//  Invariants: we and oe are never low together; the bus is never driven while oe=0; cs=1 while idle.
//  Mismatch on a sampled read: err pulses the next cycle and err_cnt increments, saturating.
//  If err_valid=0, the capture registers load and err_valid is set. The test always continues.
//  Completion: pass_cnt++, then done pulses. Total <= 10*(WAIT_CYC+2)*(ADDR_LAST+1)+4 clocks.
//  FSM: IDLE -> SETUP -> STROBE(WAIT_CYC) -> HOLD/TURN -> next op, next addr or next element -> DONE -> IDLE.
// CONFIGURATION
//  SRAM_MARCH_LOOP_EN defined:
//   after DONE, restarts at E0 with B rotated to the next background; busy stays 1 and done pulses each pass.
//   Error registers are kept across passes. Only rst stops the loop.
//  Not defined: DONE -> IDLE, busy=0.
// STRUCTURE
//  Package sram_march_pkg: element table (direction, op1, op2, op count), op enum {RD,WR}, background constants.
//  Sub-module sram_async_port: one access sequencer (SETUP/STROBE/HOLD-TURN, tristate, sample).
//   Interface is a req/ack handshake: req with rd/wr, addr and wdata; ack pulse with rdata.
// TESTING  (ADDR_LAST=15, WAIT_CYC=2, behavioural async SRAM model)
//  Clean model, bg_sel=0, start -> done within 644 clks, err_cnt=0, err_valid=0, pass_cnt=1.
//  Bit 3 at addr 5 stuck at 1, bg_sel=0 -> err_addr=5, err_exp=0x0000, err_got=0x0008, err_cnt=3.
//  Protocol checker over a full run, bg_sel=1:
//   never we=0 && oe=0; no drive while oe=0; write data 0x5555/0xAAAA only; cs=1 when idle.
//  rst asserted during E3 -> next clk cs/oe/we=1, bus Z, busy=0, err_cnt=0, elem=0.
//  start and bg_sel=2 pulsed mid-run with bg_sel=0 latched -> ignored; only 0x0000/0xFFFF written.
//  With SRAM_MARCH_LOOP_EN -> pass_cnt=2 and busy=1 after two passes, 2nd pass writes 0x5555.
//  Without SRAM_MARCH_LOOP_EN -> busy=0 after one pass.

Source files
------------

// File: rtl/sram_march_pkg.sv
// Shared definitions for the March C- SRAM tester: operation encoding,
// the six-element march table and the data background patterns.
package sram_march_pkg;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

  // One march element: direction, up to two operations and, for each one,
  // whether it uses the background (D0) or its complement (D1).
  typedef struct packed {
    logic       down;
    op_e        op1;
    logic       inv1;
    op_e        op2;
    logic       inv2;
    logic [1:0] n_ops;
  } elem_t;

  localparam logic [2:0]  ELEM_LAST = 3'd5;

  localparam logic [15:0] BG_0 = 16'h0000;
  localparam logic [15:0] BG_1 = 16'h5555;
  localparam logic [15:0] BG_2 = 16'h3333;
  localparam logic [15:0] BG_3 = 16'h0F0F;

  function automatic elem_t elem_entry(input logic [2:0] e);
    case (e)
      3'd0:    elem_entry = '{down: 1'b0, op1: OP_WR, inv1: 1'b0, op2: OP_RD, inv2: 1'b0, n_ops: 2'd1};
      3'd1:    elem_entry = '{down: 1'b0, op1: OP_RD, inv1: 1'b0, op2: OP_WR, inv2: 1'b1, n_ops: 2'd2};
      3'd2:    elem_entry = '{down: 1'b0, op1: OP_RD, inv1: 1'b1, op2: OP_WR, inv2: 1'b0, n_ops: 2'd2};
      3'd3:    elem_entry = '{down: 1'b1, op1: OP_RD, inv1: 1'b0, op2: OP_WR, inv2: 1'b1, n_ops: 2'd2};
      3'd4:    elem_entry = '{down: 1'b1, op1: OP_RD, inv1: 1'b1, op2: OP_WR, inv2: 1'b0, n_ops: 2'd2};
      default: elem_entry = '{down: 1'b0, op1: OP_RD, inv1: 1'b0, op2: OP_RD, inv2: 1'b0, n_ops: 2'd1};
    endcase
  endfunction

  function automatic logic elem_is_down(input logic [2:0] e);
    elem_t t;
    t = elem_entry(e);
    return t.down;
  endfunction

  function automatic logic [15:0] bg_pattern(input logic [1:0] sel);
    case (sel)
      2'd0:    return BG_0;
      2'd1:    return BG_1;
      2'd2:    return BG_2;
      default: return BG_3;
    endcase
  endfunction

endpackage

// File: rtl/sram_async_port.sv
// Single-access sequencer for an asynchronous SRAM. A request accepted while
// ready produces SETUP, WAIT_CYC strobe clocks and a HOLD/TURN clock; ack
// pulses during HOLD/TURN with the sampled read word. A new request may be
// accepted during HOLD/TURN so accesses run back to back.
module sram_async_port
  import sram_march_pkg::*;
#(
  parameter int AW       = 18,
  parameter int DW       = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  op_e           op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_STROBE, P_END} phase_e;

  phase_e        phase;
  logic [CW-1:0] cnt;
  logic          is_wr;
  logic          drive;
  logic [DW-1:0] wdata_q;

  assign ready     = (phase == P_IDLE) || (phase == P_END);
  assign sram_data = drive ? wdata_q : {DW{1'bz}};

  // Access sequencer; all pin controls are registered so the strobes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= P_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      drive     <= 1'b0;
      wdata_q   <= '0;
      sram_addr <= '0;
      sram_cs   <= 1'b1;
      sram_oe   <= 1'b1;
      sram_we   <= 1'b1;
      ack       <= 1'b0;
      rdata     <= '0;
    end else begin
      ack <= 1'b0;
      case (phase)
        P_IDLE, P_END: begin
          sram_oe <= 1'b1;
          sram_we <= 1'b1;
          if (req) begin
            phase     <= P_SETUP;
            sram_addr <= addr;
            wdata_q   <= wdata;
            is_wr     <= (op == OP_WR);
            drive     <= (op == OP_WR);
            sram_cs   <= 1'b0;
          end else begin
            phase   <= P_IDLE;
            drive   <= 1'b0;
            sram_cs <= 1'b1;
          end
        end
        P_SETUP: begin
          phase <= P_STROBE;
          cnt   <= '0;
          if (is_wr) sram_we <= 1'b0;
          else       sram_oe <= 1'b0;
        end
        P_STROBE: begin
          if (cnt == CNT_LAST) begin
            phase   <= P_END;
            sram_we <= 1'b1;
            sram_oe <= 1'b1;
            ack     <= 1'b1;
            if (!is_wr) rdata <= sram_data;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_march_tester.sv
// March C- tester for an external asynchronous SRAM. Walks six march
// elements over 0..ADDR_LAST with background B and its complement, counts
// read mismatches and captures the first one.
// Optional build macro SRAM_MARCH_LOOP_EN: after each pass restart at E0
// with the next background instead of returning to idle.
module sram_march_tester
  import sram_march_pkg::*;
#(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int WAIT_CYC  = 2,
  parameter int ADDR_LAST = 2**AW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    bg_sel,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   err_cnt,
  output logic          err_valid,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_got,
  output logic [7:0]    pass_cnt,
  output logic [2:0]    elem
);

  localparam logic [AW-1:0] LAST = AW'(ADDR_LAST);
  localparam logic [AW-1:0] ONE  = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state;
  logic [1:0]    bg_q;
  logic [2:0]    elem_q;
  logic [AW-1:0] pos_addr;
  logic          opi;
  logic          all_issued;
  logic          chk_rd;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] chk_exp;

  elem_t         ent;
  op_e           cur_op;
  logic          cur_inv;
  logic [15:0]   pat;
  logic [DW-1:0] d0;
  logic [DW-1:0] op_data;
  logic          req;
  logic          issue;
  logic          mismatch;
  logic [2:0]    nxt_elem;
  logic [AW-1:0] nxt_addr;
  logic          nxt_opi;
  logic          nxt_last;

  logic          port_ready;
  logic          port_ack;
  logic [DW-1:0] port_rdata;

  assign elem = elem_q;

  // Decode the current march position into the operation and data word to issue.
  always_comb begin
    ent     = elem_entry(elem_q);
    cur_op  = opi ? ent.op2 : ent.op1;
    cur_inv = opi ? ent.inv2 : ent.inv1;
    pat     = bg_pattern(bg_q);
    d0      = '0;
    for (int i = 0; i < DW; i++) d0[i] = pat[4'(i % 16)];
    op_data  = cur_inv ? ~d0 : d0;
    req      = (state == S_RUN) && !all_issued;
    issue    = req && port_ready;
    mismatch = port_ack && chk_rd && (port_rdata != chk_exp);
  end

  // Step to the next operation: second op of this address, next address, or next element.
  always_comb begin
    nxt_opi  = 1'b0;
    nxt_addr = pos_addr;
    nxt_elem = elem_q;
    nxt_last = 1'b0;
    if (!opi && ent.n_ops == 2'd2) begin
      nxt_opi = 1'b1;
    end else if (ent.down && pos_addr != '0) begin
      nxt_addr = pos_addr - ONE;
    end else if (!ent.down && pos_addr != LAST) begin
      nxt_addr = pos_addr + ONE;
    end else if (elem_q == ELEM_LAST) begin
      nxt_last = 1'b1;
    end else begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = elem_is_down(elem_q + 3'd1) ? LAST : '0;
    end
  end

  // Test controller: start/run/done sequencing, read checking and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bg_q       <= 2'd0;
      elem_q     <= 3'd0;
      pos_addr   <= '0;
      opi        <= 1'b0;
      all_issued <= 1'b0;
      chk_rd     <= 1'b0;
      chk_addr   <= '0;
      chk_exp    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= 16'd0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      err_exp    <= '0;
      err_got    <= '0;
      pass_cnt   <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (issue) begin
        chk_rd     <= (cur_op == OP_RD);
        chk_addr   <= pos_addr;
        chk_exp    <= op_data;
        opi        <= nxt_opi;
        pos_addr   <= nxt_addr;
        elem_q     <= nxt_elem;
        all_issued <= nxt_last;
      end
      if (mismatch) begin
        err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (!err_valid) begin
          err_valid <= 1'b1;
          err_addr  <= chk_addr;
          err_exp   <= chk_exp;
          err_got   <= port_rdata;
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            bg_q       <= bg_sel;
            elem_q     <= 3'd0;
            pos_addr   <= '0;
            opi        <= 1'b0;
            all_issued <= 1'b0;
            busy       <= 1'b1;
            err_cnt    <= 16'd0;
            err_valid  <= 1'b0;
            err_addr   <= '0;
            err_exp    <= '0;
            err_got    <= '0;
            pass_cnt   <= 8'd0;
          end
        end
        S_RUN: begin
          if (port_ack && all_issued) begin
            pass_cnt <= pass_cnt + 8'd1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b1;
`ifdef SRAM_MARCH_LOOP_EN
          bg_q       <= bg_q + 2'd1;
          elem_q     <= 3'd0;
          pos_addr   <= '0;
          opi        <= 1'b0;
          all_issued <= 1'b0;
          state      <= S_RUN;
`else
          busy  <= 1'b0;
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sram_async_port #(
    .AW       (AW),
    .DW       (DW),
    .WAIT_CYC (WAIT_CYC)
  ) u_port (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (cur_op),
    .addr      (pos_addr),
    .wdata     (op_data),
    .ready     (port_ready),
    .ack       (port_ack),
    .rdata     (port_rdata),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_cs   (sram_cs),
    .sram_oe   (sram_oe),
    .sram_we   (sram_we)
  );

endmodule

// File: tb/tb_sram_march_tester.sv
// Self-checking bench for sram_march_tester with a 16-word behavioural async
// SRAM (optional stuck-at-1 fault on bit 3 of word 5), a write scoreboard fed
// from a march-level model, and a pin-protocol monitor.
// Honours SRAM_MARCH_LOOP_EN to select the loop-mode expectations.
module tb_sram_march_tester;

  localparam int AW = 18, DW = 16, WAIT_CYC = 2, ADDR_LAST = 15, N = 16, RUN_MAX = 644;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    bg_sel = 2'd0;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_cs, sram_oe, sram_we;
  logic          busy, done, err, err_valid;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_got;
  logic [7:0]    pass_cnt;
  logic [2:0]    elem;

  always #5 clk = ~clk;

  sram_march_tester #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT_CYC), .ADDR_LAST(ADDR_LAST)) dut (
    .clk(clk), .rst(rst), .start(start), .bg_sel(bg_sel),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .err_valid(err_valid), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .pass_cnt(pass_cnt), .elem(elem)
  );

  // Behavioural SRAM: drives the bus whenever selected with OE low.
  logic [15:0] mem [0:15];
  logic        fault_en = 1'b0;
  logic [15:0] rd_val;

  always_comb begin
    rd_val = mem[sram_addr[3:0]];
    if (fault_en && sram_addr == 18'd5) rd_val = rd_val | 16'h0008;
  end

  assign sram_data = (!sram_cs && !sram_oe) ? rd_val : 16'hzzzz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // March-level reference: the write stream and error statistics a correct tester produces.
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [15:0] obs_w[$];
  bit          model_on = 1'b0;
  int          m_err_cnt;
  logic        m_err_valid;
  logic [AW-1:0] m_err_addr;
  logic [15:0] m_err_exp, m_err_got;

  int el_nops [6]    = '{1, 2, 2, 2, 2, 1};
  bit el_down [6]    = '{0, 0, 0, 1, 1, 0};
  bit el_wr   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit el_inv  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  function automatic logic [15:0] bgWord(input logic [1:0] b);
    case (b)
      2'd0:    return 16'h0000;
      2'd1:    return 16'h5555;
      2'd2:    return 16'h3333;
      default: return 16'h0F0F;
    endcase
  endfunction

  task automatic buildModel(input logic [1:0] b, input bit fault, input int passes);
    logic [15:0] m [16];
    logic [15:0] dat, rv;
    logic [1:0]  bb;
    int          a;
    exp_q.delete();
    m_err_cnt = 0; m_err_valid = 1'b0; m_err_addr = '0; m_err_exp = '0; m_err_got = '0;
    for (int p = 0; p < passes; p++) begin
      bb = b + 2'(p);
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < N; k++) begin
          a = el_down[e] ? (N - 1 - k) : k;
          for (int o = 0; o < el_nops[e]; o++) begin
            dat = el_inv[e][o] ? ~bgWord(bb) : bgWord(bb);
            if (el_wr[e][o]) begin
              m[a] = dat;
              exp_q.push_back('{a: 18'(a), d: dat});
            end else begin
              rv = m[a] | ((fault && a == 5) ? 16'h0008 : 16'h0000);
              if (rv != dat) begin
                if (m_err_cnt < 65535) m_err_cnt++;
                if (!m_err_valid) begin
                  m_err_valid = 1'b1; m_err_addr = 18'(a); m_err_exp = dat; m_err_got = rv;
                end
              end
            end
          end
        end
    end
  endtask

  // Compare process: pin protocol every cycle and each completed write against the model.
  logic we_prev = 1'b1, oe_prev = 1'b1;
  int   we_low = 0, oe_low = 0, err_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      we_low <= 0; oe_low <= 0; we_prev <= 1'b1; oe_prev <= 1'b1;
    end else begin
      checkOutput("we_oe_never_both_low", {31'd0, (!sram_we && !sram_oe)}, 32'd0);
      if (!sram_oe) checkOutput("bus_free_during_read", {16'd0, sram_data}, {16'd0, rd_val});
      if (!busy) checkOutput("cs_high_when_idle", {31'd0, sram_cs}, 32'd1);
      if (err) err_pulses <= err_pulses + 1;
      we_low <= sram_we ? 0 : we_low + 1;
      oe_low <= sram_oe ? 0 : oe_low + 1;
      if (!oe_prev && sram_oe) checkOutput("oe_strobe_len", oe_low, WAIT_CYC);
      if (!we_prev && sram_we) begin
        checkOutput("we_strobe_len", we_low, WAIT_CYC);
        if (!sram_cs) begin
          mem[sram_addr[3:0]] <= sram_data;
          obs_w.push_back(sram_data);
          if (model_on) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write", sram_addr, sram_data);
            end else begin
              checkOutput("write_addr", {14'd0, sram_addr}, {14'd0, exp_q[0].a});
              checkOutput("write_data", {16'd0, sram_data}, {16'd0, exp_q[0].d});
              void'(exp_q.pop_front());
            end
          end
        end
      end
      we_prev <= sram_we;
      oe_prev <= sram_oe;
    end
  end

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] b, output int t0);
    @(negedge clk); start = 1'b1; bg_sel = b; t0 = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic waitDone(input int t0, input int budget);
    bit seen = 1'b0;
    while (!seen && (cyc - t0) <= budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL done_timeout: got no done after %0d clks, expected done within %0d", cyc - t0, budget);
    end else if ((cyc - t0) > RUN_MAX) begin
      n_fail++;
      $display("[TB] FAIL run_length: got %0d clks, expected at most %0d", cyc - t0, RUN_MAX);
    end
  endtask

  task automatic checkObs(input string name, input int idx, input logic [15:0] exp);
    if (idx < obs_w.size()) checkOutput(name, {16'd0, obs_w[idx]}, {16'd0, exp});
    else begin
      n_checks++; n_fail++;
      $display("[TB] FAIL %s: got only %0d writes, expected write #%0d = %h", name, obs_w.size(), idx, exp);
    end
  endtask

  task automatic checkModelResults();
    checkOutput("err_cnt_vs_model", {16'd0, err_cnt}, m_err_cnt);
    checkOutput("err_valid_vs_model", {31'd0, err_valid}, {31'd0, m_err_valid});
    checkOutput("err_addr_vs_model", {14'd0, err_addr}, {14'd0, m_err_addr});
    checkOutput("err_exp_vs_model", {16'd0, err_exp}, {16'd0, m_err_exp});
    checkOutput("err_got_vs_model", {16'd0, err_got}, {16'd0, m_err_got});
    checkOutput("writes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, t1, base, ebase, w;

    // Reset state
    doReset();
    @(negedge clk);
    checkOutput("rst_cs", {31'd0, sram_cs}, 1);
    checkOutput("rst_oe", {31'd0, sram_oe}, 1);
    checkOutput("rst_we", {31'd0, sram_we}, 1);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_err_valid", {31'd0, err_valid}, 0);
    checkOutput("rst_err_cnt", {16'd0, err_cnt}, 0);
    checkOutput("rst_elem", {29'd0, elem}, 0);
    checkOutput("rst_addr", {14'd0, sram_addr}, 0);

    // Clean memory, background 0
    buildModel(2'd0, 1'b0, 1); model_on = 1'b1; base = obs_w.size();
    applyStimulus(2'd0, t0);
    checkOutput("busy_after_start", {31'd0, busy}, 1);
    waitDone(t0, 700);
    checkModelResults();
    checkOutput("clean_err_cnt", {16'd0, err_cnt}, 0);
    checkOutput("clean_pass_cnt", {24'd0, pass_cnt}, 1);
    checkOutput("clean_write_count", obs_w.size() - base, 80);
    checkObs("clean_first_write", base, 16'h0000);
    checkObs("clean_e1_write", base + 16, 16'hFFFF);
    @(negedge clk);
`ifdef SRAM_MARCH_LOOP_EN
    checkOutput("busy_loops_on", {31'd0, busy}, 1);
`else
    checkOutput("busy_after_pass", {31'd0, busy}, 0);
`endif
    model_on = 1'b0;
    doReset();

    // Bit 3 of word 5 stuck at 1
    fault_en = 1'b1;
    buildModel(2'd0, 1'b1, 1); model_on = 1'b1; ebase = err_pulses;
    applyStimulus(2'd0, t0);
    waitDone(t0, 700);
    checkModelResults();
    checkOutput("fault_err_cnt", {16'd0, err_cnt}, 3);
    checkOutput("fault_err_valid", {31'd0, err_valid}, 1);
    checkOutput("fault_err_addr", {14'd0, err_addr}, 5);
    checkOutput("fault_err_exp", {16'd0, err_exp}, 16'h0000);
    checkOutput("fault_err_got", {16'd0, err_got}, 16'h0008);
    checkOutput("fault_err_pulses", err_pulses - ebase, 3);
    model_on = 1'b0;
    doReset();
    fault_en = 1'b0;

    // Background 1 with the protocol monitor watching the whole run
    buildModel(2'd1, 1'b0, 1); model_on = 1'b1; base = obs_w.size();
    applyStimulus(2'd1, t0);
    waitDone(t0, 700);
    checkModelResults();
    checkObs("bg1_first_write", base, 16'h5555);
    checkObs("bg1_e1_write", base + 16, 16'hAAAA);
    model_on = 1'b0;
    doReset();

    // Reset during element 3 with one error already counted
    fault_en = 1'b1;
    applyStimulus(2'd0, t0);
    w = 0;
    while (elem != 3'd3 && w < 1000) begin @(negedge clk); w++; end
    checkOutput("reached_e3", {29'd0, elem}, 3);
    repeat (5) @(negedge clk);
    checkOutput("e3_busy", {31'd0, busy}, 1);
    checkOutput("e3_err_cnt", {16'd0, err_cnt}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_cs", {31'd0, sram_cs}, 1);
    checkOutput("abort_oe", {31'd0, sram_oe}, 1);
    checkOutput("abort_we", {31'd0, sram_we}, 1);
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_err_cnt", {16'd0, err_cnt}, 0);
    checkOutput("abort_elem", {29'd0, elem}, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    fault_en = 1'b0;

    // start and bg_sel=2 pulsed mid-run are ignored
    buildModel(2'd0, 1'b0, 1); model_on = 1'b1;
    applyStimulus(2'd0, t0);
    repeat (100) @(negedge clk);
    start = 1'b1; bg_sel = 2'd2;
    @(negedge clk);
    start = 1'b0; bg_sel = 2'd0;
    waitDone(t0, 700);
    checkModelResults();
    checkOutput("midstart_pass_cnt", {24'd0, pass_cnt}, 1);
    model_on = 1'b0;
    doReset();

`ifdef SRAM_MARCH_LOOP_EN
    // Two passes in loop mode; the second pass uses the next background
    buildModel(2'd0, 1'b0, 2); model_on = 1'b1; base = obs_w.size();
    applyStimulus(2'd0, t0);
    waitDone(t0, 700);
    checkOutput("loop_pass1_cnt", {24'd0, pass_cnt}, 1);
    checkOutput("loop_pass1_busy", {31'd0, busy}, 1);
    t1 = cyc;
    waitDone(t1, 700);
    checkOutput("loop_pass2_cnt", {24'd0, pass_cnt}, 2);
    checkOutput("loop_pass2_busy", {31'd0, busy}, 1);
    checkObs("loop_pass2_first_write", base + 80, 16'h5555);
    checkOutput("loop_writes_outstanding", exp_q.size(), 0);
    model_on = 1'b0;
    doReset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
